// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream
// of the IF/ID register. It owns the PC, sends in-order requests to a
// variable-latency instruction memory, and collects the returned words in a
// small prefetch queue. The head of that queue is presented as
// {PC+4, instruction} with a valid flag. The unit honours hazard stalls from
// ID and flushes on branch/jump redirects.
//
// Parameters
//   RESET_PC  fetch address after reset (bits [1:0] must be 0)
//   QDEPTH    prefetch queue entries (power of two, 2..8)
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_stall                 hold the presented instruction, do not pop
//   i_redirect, i_redirect_pc  flush and refetch from the target (word aligned)
//   o_imem_req, o_imem_addr request to instruction memory (addr = PC)
//   i_imem_gnt              request accepted this cycle
//   i_imem_rvalid, i_imem_rdata  in-order response from instruction memory
//   o_valid, o_next_pc, o_data   head of the prefetch queue (zeros when empty)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_data
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] qcount_q, qcount_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] q_rd_q, q_rd_d;
    logic [PW-1:0] q_wr_q, q_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;

    logic [31:0]   q_data_q [QDEPTH];
    logic [31:0]   q_data_d [QDEPTH];
    logic [31:0]   q_npc_q  [QDEPTH];
    logic [31:0]   q_npc_d  [QDEPTH];
    logic [31:0]   tag_q    [QDEPTH];
    logic [31:0]   tag_d    [QDEPTH];

    logic          pop;
    logic          imem_req;
    logic          accept;
    logic          resp;
    logic          push;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_target;

    // Handshake decode. A slot is reserved for every outstanding request so
    // the queue can never overflow. The head being popped this cycle frees
    // its slot already, which is what lets a 1-cycle memory sustain one
    // instruction per cycle with only two entries.
    always_comb begin
        pop       = (qcount_q != '0) && !i_stall && !i_redirect;
        occupancy = (CW + 1)'(qcount_q) + (CW + 1)'(outstanding_q) - (CW + 1)'(pop);
        imem_req  = !i_rst && !i_redirect && (occupancy < DEPTH_C);
        accept    = imem_req && i_imem_gnt;
        // rvalid with nothing outstanding is a stale response from before reset
        resp      = i_imem_rvalid && (outstanding_q != '0);
        // responses owed to a flushed stream, or landing in a redirect cycle, are discarded
        push      = resp && (drop_q == '0) && !i_redirect;
        redirect_target = i_redirect_pc & ~32'h3;
    end

    // Next-state computation for PC, counters, pointers and storage arrays.
    // Redirect overrides the normal queue/PC update; the drop count becomes
    // whatever is still in flight once this cycle's response is accounted for.
    always_comb begin
        pc_d          = pc_q;
        qcount_d      = qcount_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
        drop_d        = drop_q;
        q_rd_d        = q_rd_q;
        q_wr_d        = q_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        q_data_d      = q_data_q;
        q_npc_d       = q_npc_q;
        tag_d         = tag_q;

        if (accept) begin
            tag_d[tag_wr_q] = pc_q + 32'd4;
            tag_wr_d        = tag_wr_q + PW'(1);
            pc_d            = pc_q + 32'd4;
        end

        if (resp) begin
            tag_rd_d = tag_rd_q + PW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end

        if (i_redirect) begin
            pc_d     = redirect_target;
            qcount_d = '0;
            q_rd_d   = '0;
            q_wr_d   = '0;
            drop_d   = outstanding_d;
        end else begin
            if (push) begin
                q_data_d[q_wr_q] = i_imem_rdata;
                q_npc_d[q_wr_q]  = tag_q[tag_rd_q];
                q_wr_d           = q_wr_q + PW'(1);
            end
            if (pop) begin
                q_rd_d = q_rd_q + PW'(1);
            end
            qcount_d = qcount_q + CW'(push) - CW'(pop);
        end
    end

    // Control state: everything that must be cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q          <= RESET_PC;
            qcount_q      <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            q_rd_q        <= '0;
            q_wr_q        <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            qcount_q      <= qcount_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            q_rd_q        <= q_rd_d;
            q_wr_q        <= q_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
        end
    end

    // Data storage: contents are only ever read through valid pointers, so
    // they need no reset.
    always_ff @(posedge i_clk) begin
        q_data_q <= q_data_d;
        q_npc_q  <= q_npc_d;
        tag_q    <= tag_d;
    end

    assign o_imem_req  = imem_req;
    assign o_imem_addr = pc_q;
    assign o_valid     = !i_rst && (qcount_q != '0);
    assign o_next_pc   = o_valid ? q_npc_q[q_rd_q]  : 32'h0;
    assign o_data      = o_valid ? q_data_q[q_rd_q] : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. A transaction-level model (queues of
// in-flight requests and of buffered instructions) predicts every output each
// cycle; a behavioural memory returns data equal to the address in request
// order. Directed scenarios pin literal values, then randomized phases mix
// grants, latencies, stalls, redirects and resets.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int          QD     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_next_pc;
    logic [31:0] o_data;

    always #5 i_clk = ~i_clk;

    if_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .o_next_pc     (o_next_pc),
        .o_data        (o_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic        dropped;
    } pend_t;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] data;
    } out_t;

    pend_t       pendQ[$];
    out_t        outQ[$];
    logic [31:0] memQ[$];
    logic [31:0] modelPc;

    logic        expValid;
    logic [31:0] expNpc;
    logic [31:0] expData;
    logic        expReq;
    logic [31:0] expAddr;

    int pctGnt, pctRvalid, pctStall, pctRedirect, pctRst;
    logic        forceRst;
    logic        forceRedirect;
    logic [31:0] forceTarget;
    logic        injectStale;
    logic        memResp;

    int cmpCount  = 0;
    int failCount = 0;

    function automatic bit chance(int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Redirect targets lean towards the top of the address space so the
    // 32-bit PC wrap is exercised, and include unaligned low bits.
    function automatic logic [31:0] randomTarget();
        int sel;
        sel = $urandom_range(3);
        if (sel == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
        if (sel == 1) return 32'($urandom_range(255));
        return $urandom;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic pin(string name, logic [31:0] dutVal, logic [31:0] modelVal, logic [31:0] lit);
        check(name, dutVal, lit);
        check({name, "_model"}, modelVal, lit);
    endtask

    // Drive one cycle's inputs from the knobs and the behavioural memory.
    task automatic applyStimulus();
        i_rst   = forceRst || chance(pctRst);
        i_stall = chance(pctStall);
        if (forceRedirect) begin
            i_redirect    = 1'b1;
            i_redirect_pc = forceTarget;
        end else begin
            i_redirect    = chance(pctRedirect);
            i_redirect_pc = randomTarget();
        end
        i_imem_gnt = chance(pctGnt);
        memResp    = 1'b0;
        if (memQ.size() != 0 && chance(pctRvalid)) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = memQ[0];
            memResp       = 1'b1;
        end else if (injectStale) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
        end
    endtask

    // Compare the DUT against the model, then advance the model across the edge.
    task automatic checkOutput();
        int    occ;
        bit    doPop;
        bit    granted;
        pend_t p;
        out_t  e;

        doPop    = !i_rst && outQ.size() != 0 && !i_stall && !i_redirect;
        occ      = outQ.size() + pendQ.size() - (doPop ? 1 : 0);
        expValid = !i_rst && outQ.size() != 0;
        expNpc   = expValid ? outQ[0].npc  : 32'h0;
        expData  = expValid ? outQ[0].data : 32'h0;
        expReq   = !i_rst && !i_redirect && occ < QD;
        expAddr  = modelPc;

        check("o_valid",     32'(o_valid),    32'(expValid));
        check("o_next_pc",   o_next_pc,       expNpc);
        check("o_data",      o_data,          expData);
        check("o_imem_req",  32'(o_imem_req), 32'(expReq));
        if (!i_rst) check("o_imem_addr", o_imem_addr, expAddr);

        if (i_rst) begin
            outQ.delete();
            pendQ.delete();
            memQ.delete();
            modelPc = RST_PC;
        end else begin
            if (memResp) void'(memQ.pop_front());
            if (doPop) void'(outQ.pop_front());
            if (i_imem_rvalid && pendQ.size() != 0) begin
                p = pendQ.pop_front();
                if (!p.dropped && !i_redirect) begin
                    e.npc  = p.addr + 32'd4;
                    e.data = i_imem_rdata;
                    outQ.push_back(e);
                end
            end
            granted = expReq && i_imem_gnt;
            if (granted) begin
                p.addr    = modelPc;
                p.dropped = 1'b0;
                pendQ.push_back(p);
                memQ.push_back(modelPc);
                modelPc = modelPc + 32'd4;
            end
            if (i_redirect) begin
                outQ.delete();
                foreach (pendQ[k]) pendQ[k].dropped = 1'b1;
                modelPc = {i_redirect_pc[31:2], 2'b00};
            end
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
        applyStimulus();
        @(negedge i_clk);
        checkOutput();
    endtask

    task automatic steadyKnobs();
        pctGnt = 100; pctRvalid = 100; pctStall = 0; pctRedirect = 0; pctRst = 0;
        forceRst = 1'b0; forceRedirect = 1'b0; injectStale = 1'b0;
    endtask

    task automatic doReset();
        steadyKnobs();
        forceRst = 1'b1;
        cycle();
        pin("rst_valid", 32'(o_valid),    32'(expValid), 32'd0);
        pin("rst_data",  o_data,          expData,       32'd0);
        pin("rst_npc",   o_next_pc,       expNpc,        32'd0);
        pin("rst_req",   32'(o_imem_req), 32'(expReq),   32'd0);
        forceRst = 1'b0;
    endtask

    task automatic pinOut(string name, logic [31:0] npc, logic [31:0] data);
        pin({name, "_valid"}, 32'(o_valid), 32'(expValid), 32'd1);
        pin({name, "_npc"},   o_next_pc,    expNpc,        npc);
        pin({name, "_data"},  o_data,       expData,       data);
    endtask

    int phaseGnt[6]   = '{70, 100, 50, 100, 30, 90};
    int phaseRv[6]    = '{60, 100, 30, 100, 90, 50};
    int phaseStall[6] = '{20,   0, 50,  30, 10, 60};
    int phaseRedir[6] = '{ 5,   0, 10,  15,  3, 20};
    int phaseRst[6]   = '{ 1,   0,  2,   0,  1,  1};

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
        modelPc = RST_PC;
        memResp = 1'b0;
        forceTarget = 32'h0;

        // Streaming, stall, then redirect with two responses in flight
        doReset();
        cycle(); cycle();
        cycle(); pinOut("s1_c2", 32'd4,  32'd0);
        cycle(); pinOut("s1_c3", 32'd8,  32'd4);
        cycle(); pinOut("s1_c4", 32'd12, 32'd8);
        pctStall = 100;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pinOut("s2_stall", 32'd16, 32'd12);
            pin("s2_req", 32'(o_imem_req), 32'(expReq), 32'd0);
        end
        pctStall = 0;
        cycle(); pinOut("s2_c9",  32'd16, 32'd12);
        cycle(); pinOut("s2_c10", 32'd20, 32'd16);
        cycle(); pinOut("s2_c11", 32'd24, 32'd20);
        pctRvalid = 0;
        cycle(); pinOut("s3_c12", 32'd28, 32'd24);
        forceRedirect = 1'b1; forceTarget = 32'h100;
        cycle();
        pin("s3_redir_valid", 32'(o_valid),    32'(expValid), 32'd0);
        pin("s3_redir_req",   32'(o_imem_req), 32'(expReq),   32'd0);
        forceRedirect = 1'b0; pctRvalid = 100;
        cycle();
        cycle();
        pin("s3_addr", o_imem_addr,     expAddr,     32'h100);
        pin("s3_req",  32'(o_imem_req), 32'(expReq), 32'd1);
        cycle();
        cycle(); pinOut("s3_first", 32'h104, 32'h100);

        // Grant withheld for five cycles
        doReset();
        for (int i = 0; i < 5; i++) cycle();
        pinOut("s4_c4", 32'd12, 32'd8);
        pctGnt = 0;
        for (int i = 5; i < 10; i++) begin
            cycle();
            pin("s4_req",  32'(o_imem_req), 32'(expReq), 32'd1);
            pin("s4_addr", o_imem_addr,     expAddr,     32'd20);
            if (i == 7) begin
                pin("s4_empty_valid", 32'(o_valid), 32'(expValid), 32'd0);
                pin("s4_empty_data",  o_data,       expData,       32'd0);
            end
        end
        pctGnt = 100;
        cycle(); cycle();
        cycle(); pinOut("s4_resume", 32'd24, 32'd20);

        // Redirect to an unaligned target coinciding with rvalid and pop
        doReset();
        cycle(); cycle(); cycle();
        forceRedirect = 1'b1; forceTarget = 32'h203;
        cycle();
        pin("s5_redir_req", 32'(o_imem_req), 32'(expReq), 32'd0);
        forceRedirect = 1'b0;
        cycle();
        pin("s5_addr",  o_imem_addr,  expAddr,       32'h200);
        pin("s5_valid", 32'(o_valid), 32'(expValid), 32'd0);
        cycle();
        cycle(); pinOut("s5_first", 32'h204, 32'h200);

        // Reset with a full queue, then a stale response
        doReset();
        for (int i = 0; i < 5; i++) cycle();
        pctStall = 100;
        cycle(); cycle();
        pctStall = 0;
        forceRst = 1'b1;
        cycle();
        pin("s6_rst_valid", 32'(o_valid), 32'(expValid), 32'd0);
        pin("s6_rst_data",  o_data,       expData,       32'd0);
        forceRst = 1'b0; injectStale = 1'b1;
        cycle();
        pin("s6_addr",  o_imem_addr,     expAddr,       RST_PC);
        pin("s6_req",   32'(o_imem_req), 32'(expReq),   32'd1);
        pin("s6_valid", 32'(o_valid),    32'(expValid), 32'd0);
        injectStale = 1'b0;
        cycle();
        cycle(); pinOut("s6_first", RST_PC + 32'd4, RST_PC);

        // Randomized phases
        doReset();
        for (int ph = 0; ph < 6; ph++) begin
            pctGnt      = phaseGnt[ph];
            pctRvalid   = phaseRv[ph];
            pctStall    = phaseStall[ph];
            pctRedirect = phaseRedir[ph];
            pctRst      = phaseRst[ph];
            for (int i = 0; i < 500; i++) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule
